// File: rtl/frv_rng_prng.sv
// Seedable 32-bit Galois LFSR responder on the core's RNG request/response channel,
// with post-seed mixing and a reseed-interval health monitor.
module frv_rng_prng #(
   parameter logic [31:0] LFSR_TAPS       = 32'h8020_0003,
   parameter logic [31:0] RESET_STATE     = 32'h0000_0001,
   parameter int unsigned SEED_MIX_CYCLES = 4,
   parameter logic [15:0] RESEED_LIMIT    = 16'd1024
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        rng_req_valid,
   input  logic [2:0]  rng_req_op,
   input  logic [31:0] rng_req_data,
   output logic        rng_req_ready,
   output logic        rng_rsp_valid,
   output logic [2:0]  rng_rsp_status,
   output logic [31:0] rng_rsp_data,
   input  logic        rng_rsp_ready
);

   localparam logic [2:0] OpSeed = 3'b001;
   localparam logic [2:0] OpSamp = 3'b010;

   localparam logic [2:0] StatNoInit    = 3'b000;
   localparam logic [2:0] StatUnhealthy = 3'b001;
   localparam logic [2:0] StatHealthy   = 3'b100;

   localparam logic [7:0] MixLast = 8'(SEED_MIX_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StMix, StRsp} state_t;

   state_t      state_q;
   logic [31:0] lfsr_q;
   logic        seeded_q;
   logic [15:0] samp_cnt_q;
   logic [7:0]  mix_cnt_q;
   logic        rsp_valid_q;
   logic [2:0]  rsp_status_q;
   logic [31:0] rsp_data_q;

   logic [31:0] lfsr_step;
   logic [31:0] seed_mixed;
   logic        healthy;
   logic [2:0]  cur_status;

   always_comb begin
      lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
      // An all-zero state would lock the LFSR, so fall back to 1.
      seed_mixed = lfsr_q ^ rng_req_data;
      if (seed_mixed == 32'h0) begin
         seed_mixed = 32'h1;
      end
      healthy = seeded_q && (samp_cnt_q != RESEED_LIMIT);
      if (!seeded_q) begin
         cur_status = StatNoInit;
      end else if (healthy) begin
         cur_status = StatHealthy;
      end else begin
         cur_status = StatUnhealthy;
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q      <= StIdle;
         lfsr_q       <= RESET_STATE;
         seeded_q     <= 1'b0;
         samp_cnt_q   <= 16'd0;
         mix_cnt_q    <= 8'd0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= StatNoInit;
         rsp_data_q   <= 32'h0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rng_req_valid) begin
                  case (rng_req_op)
                     OpSeed: begin
                        lfsr_q     <= seed_mixed;
                        mix_cnt_q  <= 8'd0;
                        seeded_q   <= 1'b1;
                        samp_cnt_q <= 16'd0;
                        state_q    <= StMix;
                     end
                     OpSamp: begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= cur_status;
                        state_q      <= StRsp;
                        if (healthy) begin
                           rsp_data_q <= lfsr_q;
                           lfsr_q     <= lfsr_step;
                           samp_cnt_q <= samp_cnt_q + 16'd1;
                        end else begin
                           rsp_data_q <= 32'h0;
                        end
                     end
                     default: begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= cur_status;
                        rsp_data_q   <= 32'h0;
                        state_q      <= StRsp;
                     end
                  endcase
               end
            end
            StMix: begin
               lfsr_q    <= lfsr_step;
               mix_cnt_q <= mix_cnt_q + 8'd1;
               if (mix_cnt_q == MixLast) begin
                  rsp_valid_q  <= 1'b1;
                  rsp_status_q <= StatHealthy;
                  rsp_data_q   <= 32'h0;
                  state_q      <= StRsp;
               end
            end
            StRsp: begin
               if (rng_rsp_ready) begin
                  rsp_valid_q  <= 1'b0;
                  rsp_status_q <= StatNoInit;
                  rsp_data_q   <= 32'h0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rng_req_ready  = (state_q == StIdle);
   assign rng_rsp_valid  = rsp_valid_q;
   assign rng_rsp_status = rsp_status_q;
   assign rng_rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_frv_rng_prng.sv
// Directed bench for frv_rng_prng with RESEED_LIMIT = 2 so the health monitor
// saturates within a handful of samples.
module tb_frv_rng_prng;

   localparam logic [2:0] OpSeed = 3'b001;
   localparam logic [2:0] OpSamp = 3'b010;
   localparam logic [2:0] OpTest = 3'b100;
   localparam logic [2:0] OpNop  = 3'b111;

   logic        g_clk;
   logic        g_resetn;
   logic        rng_req_valid;
   logic [2:0]  rng_req_op;
   logic [31:0] rng_req_data;
   logic        rng_req_ready;
   logic        rng_rsp_valid;
   logic [2:0]  rng_rsp_status;
   logic [31:0] rng_rsp_data;
   logic        rng_rsp_ready;

   int n_assert = 0;
   int n_fail   = 0;

   frv_rng_prng #(
      .LFSR_TAPS       (32'h8020_0003),
      .RESET_STATE     (32'h0000_0001),
      .SEED_MIX_CYCLES (4),
      .RESEED_LIMIT    (16'd2)
   ) dut (
      .g_clk          (g_clk),
      .g_resetn       (g_resetn),
      .rng_req_valid  (rng_req_valid),
      .rng_req_op     (rng_req_op),
      .rng_req_data   (rng_req_data),
      .rng_req_ready  (rng_req_ready),
      .rng_rsp_valid  (rng_rsp_valid),
      .rng_rsp_status (rng_rsp_status),
      .rng_rsp_data   (rng_rsp_data),
      .rng_rsp_ready  (rng_rsp_ready)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the request is accepted on the following posedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] data);
      chk("req_ready_before_issue", 32'(rng_req_ready), 32'd1);
      rng_req_valid = 1'b1;
      rng_req_op    = op;
      rng_req_data  = data;
      @(posedge g_clk);
      @(negedge g_clk);
      rng_req_valid = 1'b0;
      rng_req_op    = 3'b000;
      rng_req_data  = 32'h0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rng_rsp_valid && lat < 20) begin
         @(negedge g_clk);
         lat++;
      end
   endtask

   task automatic take();
      rng_rsp_ready = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      rng_rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", 32'(rng_rsp_valid), 32'd0);
      chk("req_ready_after_hs", 32'(rng_req_ready), 32'd1);
   endtask

   task automatic simple_op(input string tag, input logic [2:0] op,
                            input logic [2:0] exp_status, input logic [31:0] exp_data);
      issue(op, 32'h0);
      chk({tag, "_valid_t1"}, 32'(rng_rsp_valid), 32'd1);
      chk({tag, "_status"}, 32'(rng_rsp_status), 32'(exp_status));
      chk({tag, "_data"}, rng_rsp_data, exp_data);
      take();
   endtask

   task automatic seed_op(input string tag, input logic [31:0] data);
      int lat;
      issue(OpSeed, data);
      wait_rsp(lat);
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_status"}, 32'(rng_rsp_status), 32'd4);
      chk({tag, "_data"}, rng_rsp_data, 32'h0);
      take();
   endtask

   initial begin
      bit seen;
      g_resetn      = 1'b0;
      rng_req_valid = 1'b0;
      rng_req_op    = 3'b000;
      rng_req_data  = 32'h0;
      rng_rsp_ready = 1'b0;

      repeat (3) @(negedge g_clk);
      chk("rst_req_ready", 32'(rng_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rng_rsp_valid), 32'd0);
      chk("rst_rsp_status", 32'(rng_rsp_status), 32'd0);
      chk("rst_rsp_data", rng_rsp_data, 32'h0);
      g_resetn = 1'b1;
      @(negedge g_clk);

      simple_op("test_noinit", OpTest, 3'b000, 32'h0);
      simple_op("samp_noinit", OpSamp, 3'b000, 32'h0);
      simple_op("nop_noinit", OpNop, 3'b000, 32'h0);

      // Unadvanced state 1 xor seed 1 hits the zero guard; 4 mix steps follow.
      seed_op("seed1", 32'h0000_0001);

      // First sample under 5 cycles of backpressure.
      issue(OpSamp, 32'h0);
      chk("samp1_valid_t1", 32'(rng_rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_data", rng_rsp_data, 32'hB02C_0003);
         chk("bp_status", 32'(rng_rsp_status), 32'd4);
         chk("bp_req_ready", 32'(rng_req_ready), 32'd0);
         chk("bp_rsp_valid", 32'(rng_rsp_valid), 32'd1);
         @(negedge g_clk);
      end
      take();

      simple_op("samp2", OpSamp, 3'b100, 32'hD836_0002);
      simple_op("samp3_unhealthy", OpSamp, 3'b001, 32'h0);
      simple_op("samp4_saturated", OpSamp, 3'b001, 32'h0);
      simple_op("test_unhealthy", OpTest, 3'b001, 32'h0);

      seed_op("reseed", 32'h1234_5678);
      simple_op("test_reseeded", OpTest, 3'b100, 32'h0);

      // Reset during the second MIX cycle abandons the SEED.
      issue(OpSeed, 32'hCAFE_F00D);
      chk("mix_req_ready", 32'(rng_req_ready), 32'd0);
      @(negedge g_clk);
      g_resetn = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(rng_req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rng_rsp_valid), 32'd0);
      chk("midrst_rsp_status", 32'(rng_rsp_status), 32'd0);
      chk("midrst_rsp_data", rng_rsp_data, 32'h0);
      @(negedge g_clk);
      g_resetn = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge g_clk);
         if (rng_rsp_valid) seen = 1'b1;
      end
      chk("no_rsp_after_rst", 32'(seen), 32'd0);
      simple_op("test_after_rst", OpTest, 3'b000, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/frv_rng_prng.md
# frv_rng_prng

- Responder on the core's RNG request/response channel: it consumes `rng_req_*` and produces `rng_rsp_*`.
- Implements a seedable 32-bit Galois LFSR with a post-seed mixing phase and a reseed-interval health monitor.
- Serves one request at a time. Instantiated beside the core, wired port-for-port to its RNG channel.
- Used when `MASKING_ISE_TRNG = 0`.

## Interface

Parameters:
- `LFSR_TAPS`, default `32'h8020_0003`: Galois feedback mask, right-shift form (x^32+x^22+x^2+x+1).
- `RESET_STATE`, default `32'h0000_0001`: LFSR value after reset. Must be nonzero.
- `SEED_MIX_CYCLES`, default `4`: LFSR steps applied after a SEED. Range 1..255.
- `RESEED_LIMIT`, default `16'd1024`: healthy samples allowed before a reseed is required. Must be ≥1.

Ports:
- `g_clk` in 1: global clock. One clock domain only.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `rng_req_valid` in 1: request present.
- `rng_req_op` in 3: `3'b001` SEED, `3'b010` SAMP, `3'b100` TEST. All other codes are NOP.
- `rng_req_data` in 32: seed material. Used by SEED only.
- `rng_req_ready` out 1: request accepted when high together with `rng_req_valid`.
- `rng_rsp_valid` out 1: response present.
- `rng_rsp_status` out 3: `3'b000` NO_INIT, `3'b001` UNHEALTHY, `3'b100` HEALTHY.
- `rng_rsp_data` out 32: sample value. Zero for every op except a healthy SAMP.
- `rng_rsp_ready` in 1: core accepts the response.

## Operation

State machine:
- IDLE: `rng_req_ready = 1`. On accept, SEED goes to MIX; every other op goes to RSP.
- MIX: one LFSR step per cycle. A counter runs 0..`SEED_MIX_CYCLES`-1. On the last step, go to RSP.
- RSP: `rng_rsp_valid = 1`. On `rng_rsp_valid && rng_rsp_ready`, go to IDLE.

LFSR step: `s <= (s >> 1) ^ (s[0] ? LFSR_TAPS : 0)`.

Per-op behaviour:
- SEED:
  - `s <= s ^ rng_req_data`. If the result is zero, load `32'h1` instead.
  - Then SEED_MIX_CYCLES steps.
  - Clears the sample counter and sets health to HEALTHY.
  - Response: status HEALTHY, data 0.
- SAMP:
  - Captures status before the sample.
  - If HEALTHY: data = current `s`, then `s` steps once and the sample counter increments, saturating at `RESEED_LIMIT`.
  - Otherwise: data 0, no step, no count.
- TEST and NOP: data 0, status = current health, no state change.
- Health: NO_INIT from reset until the first SEED. When the sample counter equals `RESEED_LIMIT`, status becomes UNHEALTHY and stays there until the next SEED.
- Response registers: captured on entry to RSP and held stable until the handshake completes.
- Requests presented outside IDLE are not accepted; `rng_req_ready = 0`.

## Timing

- Reset values (async, immediate on `g_resetn` low):
  - FSM IDLE, `s = RESET_STATE`, health NO_INIT, sample counter 0.
  - `rng_req_ready = 1`.
  - `rng_rsp_valid = 0`, `rng_rsp_status = 3'b000`, `rng_rsp_data = 0`.
- `rng_req_ready` is decoded from FSM state only. It has no combinational path from any input.
- SAMP/TEST/NOP: accepted in cycle T; `rng_rsp_valid` is high from T+1.
- SEED: accepted in cycle T; `rng_rsp_valid` is high from T+1+`SEED_MIX_CYCLES`.
- Response handshake in cycle R: `rng_rsp_valid = 0` and `rng_req_ready = 1` at R+1. A new request cannot be accepted in R itself. Minimum spacing between accepts is 2 cycles.
- Backpressure: `rng_rsp_data` and `rng_rsp_status` must not change while `rng_rsp_valid && !rng_rsp_ready`.
- Reset mid-MIX or mid-RSP: the transaction is abandoned. No response is issued after reset is released, and health returns to NO_INIT.
- Sample counter at `RESEED_LIMIT`: saturates and does not wrap.

## Test plan

- Reset, then TEST → `rng_req_ready = 1` throughout reset. Response at T+1 with status `3'b000` and data 0.
- SAMP before any SEED → status `3'b000`, data 0. The LFSR must not advance: a later SEED of `32'h1` yields the zero-guard path.
- SEED with data `32'h0000_0001` (state becomes 0, forced to 1; defaults) → response at T+5, status `3'b100`, data 0.
  - First SAMP returns `32'hB02C_0003` with status `3'b100`.
  - Second SAMP returns `32'hD836_0002`.
- Backpressure: hold `rng_rsp_ready` low for 5 cycles after a SAMP → data/status stable and `rng_req_ready = 0` for the whole hold. Raise ready → `rng_req_ready = 1` one cycle later.
- With `RESEED_LIMIT = 2`: SEED, then 2 SAMPs → both status `3'b100`. Third SAMP → status `3'b001`, data 0. A new SEED restores `3'b100`.
- Drop `g_resetn` during cycle 2 of MIX → all outputs return to reset values immediately. After release, no response appears and TEST reports `3'b000`.
